// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch PC/ROM-word pairing FIFO feeding the decode stage
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue goes straight to ID.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               stall,
  input  logic                     flush,
  input  logic                     ce_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [DATA_W-1:0]        inst_i,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [DATA_W-1:0]        id_inst,
  output logic                     id_valid,
  output logic                     fetch_stall_req,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              req_valid;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];

  logic [CW:0] occupancy;
  logic        accept;
  logic        bypass;
  logic        push;
  logic        pop;
  logic        unused_stall;

  assign unused_stall = &{1'b0, stall[5:3]};

  // Pending request counts as occupied so a full queue never sees a push.
  assign occupancy       = {1'b0, count} + {{CW{1'b0}}, req_valid};
  assign fetch_stall_req = (occupancy >= DEPTH_W);
  assign accept          = ce_i & ~stall[0] & ~flush & ~fetch_stall_req;

`ifdef FETCH_BYPASS_EN
  assign bypass = req_valid & ~flush & ~stall[1] & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = req_valid & ~flush & ~bypass;
  assign pop  = ~flush & ~stall[1] & (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= req_pc;
      mem_inst[wr_ptr] <= inst_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_valid <= 1'b0;
      req_pc    <= '0;
      id_pc     <= '0;
      id_inst   <= '0;
      id_valid  <= 1'b0;
    end else begin
      req_valid <= accept;
      if (accept) begin
        req_pc <= pc_i;
      end
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        id_pc    <= '0;
        id_inst  <= '0;
        id_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (stall[1]) begin
          if (!stall[2]) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
          end
        end else if (count != '0) begin
          id_pc    <= mem_pc[rd_ptr];
          id_inst  <= mem_inst[rd_ptr];
          id_valid <= 1'b1;
        end else if (bypass) begin
          id_pc    <= req_pc;
          id_inst  <= inst_i;
          id_valid <= 1'b1;
        end else begin
          id_pc    <= '0;
          id_inst  <= '0;
          id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized bench for if_fetch_queue against a queue-based model
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 2;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        fetch_stall_req;
  logic [2:0]  count;

  if_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ce_i(ce_i),
    .pc_i(pc_i), .inst_i(inst_i), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .fetch_stall_req(fetch_stall_req), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: queue of {pc, inst}, pending request slot, ID registers
  logic [63:0] mq[$];
  bit          m_req;
  logic [31:0] m_req_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  bit          m_id_valid;
  bit          m_acc;
  logic [31:0] prev_pc;

  wire [68:0] dut_vec = {id_valid, id_pc, id_inst, count, fetch_stall_req};

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h2401_0000 + (a >> 2);
  endfunction

  function automatic logic [68:0] model_vec();
    return {m_id_valid, m_id_pc, m_id_inst, 3'(mq.size()),
            1'((mq.size() + int'(m_req)) >= DEPTH)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_req_pc = 0; m_acc = 0;
    m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    prev_pc = 0;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; flush = 0; ce_i = 0; pc_i = 0; inst_i = 0;
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the same edge, sample after it
  task automatic cycle(input logic [5:0] st, input bit fl, input bit ce, input logic [31:0] pc);
    bit sreq;
    bit byp;
    logic [63:0] e;
    stall = st; flush = fl; ce_i = ce;
    inst_i = rom(prev_pc);
    pc_i = pc; prev_pc = pc;
    sreq = (mq.size() + int'(m_req)) >= DEPTH;
    m_acc = ce && !st[0] && !fl && !sreq;
    if (fl) begin
      mq.delete();
      m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
    end else begin
      byp = BYP && mq.size() == 0 && m_req && !st[1];
      if (st[1]) begin
        if (!st[2]) begin
          m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
        end
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_id_pc = e[63:32]; m_id_inst = e[31:0]; m_id_valid = 1;
      end else if (byp) begin
        m_id_pc = m_req_pc; m_id_inst = inst_i; m_id_valid = 1;
      end else begin
        m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
      end
      if (m_req && !byp) mq.push_back({m_req_pc, inst_i});
    end
    m_req = m_acc;
    if (m_acc) m_req_pc = pc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; ce_i = 1; pc_i = 32'h40; inst_i = 32'hdead_beef;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 69'h0) begin
      errors++; $display("FAIL reset_async: got %h required %h", dut_vec, 69'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== 69'h0) begin
      errors++; $display("FAIL reset_held: got %h required %h", dut_vec, 69'h0);
    end
    rst = 0;
  endtask

  task automatic test_sequential();
    int first = -1;
    int maxc = 0;
    logic [31:0] got[$];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(6'b0, 0, i < 3, (i < 3) ? 32'(i * 4) : 32'h0);
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL seq_cycle%0d: got %h required %h", i, dut_vec, model_vec());
      end
      if (id_valid) begin
        if (first < 0) first = i + 1;
        got.push_back(id_pc);
      end
      if (int'(count) > maxc) maxc = int'(count);
    end
    checks++;
    if (first != LAT) begin
      errors++; $display("FAIL seq_latency: got %0d required %0d", first, LAT);
    end
    checks++;
    if (maxc != (BYP ? 0 : 1)) begin
      errors++; $display("FAIL seq_max_count: got %0d required %0d", maxc, BYP ? 0 : 1);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      errors++; $display("FAIL seq_order: got %0d entries first %h required 3 entries 0,4,8",
                         got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_full();
    logic [31:0] pc = 32'h100;
    logic [31:0] got[$];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(6'b000110, 0, 1, pc);
      if (m_acc) pc += 4;
      checks++;
      if (dut_vec !== model_vec() || count > 3'(DEPTH)) begin
        errors++; $display("FAIL full_fill%0d: got %h required %h", i, dut_vec, model_vec());
      end
    end
    checks++;
    if (count !== 3'd4 || fetch_stall_req !== 1'b1) begin
      errors++; $display("FAIL full_level: got count=%0d sreq=%0b required count=4 sreq=1",
                         count, fetch_stall_req);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(6'b0, 0, 0, pc);
      if (id_valid) got.push_back(id_pc);
    end
    checks++;
    if (got.size() != 4 || got[0] !== 32'h100 || got[1] !== 32'h104 ||
        got[2] !== 32'h108 || got[3] !== 32'h10c) begin
      errors++; $display("FAIL full_drain: got %0d entries required 0x100..0x10c", got.size());
    end
  endtask

  task automatic test_bubble();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(6'b000110, 0, i < 3, 32'h100 + 32'(i * 4));
    cycle(6'b000010, 0, 0, 32'h0);
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || count !== 3'd3) begin
      errors++; $display("FAIL bubble: got valid=%0b inst=%h count=%0d required 0,0,3",
                         id_valid, id_inst, count);
    end
    cycle(6'b0, 0, 0, 32'h0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== rom(32'h100)) begin
      errors++; $display("FAIL bubble_head: got valid=%0b pc=%h required 1 pc=00000100",
                         id_valid, id_pc);
    end
  endtask

  task automatic test_flush();
    logic [31:0] pc = 32'h4000_0180;
    logic [31:0] got[$];
    bool_dummy: begin end
    do_reset();
    for (int i = 0; i < 4; i++) cycle(6'b000110, 0, 1, 32'h100 + 32'(i * 4));
    checks++;
    if (count !== 3'd3 || fetch_stall_req !== 1'b1) begin
      errors++; $display("FAIL flush_setup: got count=%0d sreq=%0b required 3,1", count, fetch_stall_req);
    end
    cycle(6'b000110, 1, 1, pc);
    checks++;
    if (count !== 3'd0 || id_valid !== 1'b0 || id_inst !== 32'h0) begin
      errors++; $display("FAIL flush_clear: got count=%0d valid=%0b inst=%h required 0,0,0",
                         count, id_valid, id_inst);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(6'b0, 0, pc < 32'h4000_018c, pc);
      if (m_acc) pc += 4;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL flush_after%0d: got %h required %h", i, dut_vec, model_vec());
      end
      if (id_valid) got.push_back(id_pc);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 32'h4000_0180 || got[2] !== 32'h4000_0188) begin
      errors++; $display("FAIL flush_refetch: got %0d entries required 3 from 40000180", got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] pc = 32'h200;
    int first_pc_ok = 0;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(6'b000110, 0, i < 2, 32'h100 + 32'(i * 4));
    checks++;
    if (count !== 3'd2) begin
      errors++; $display("FAIL rstmid_setup: got count=%0d required 2", count);
    end
    #3 rst = 1;
    #1;
    checks++;
    if (dut_vec !== 69'h0) begin
      errors++; $display("FAIL rstmid_async: got %h required %h", dut_vec, 69'h0);
    end
    model_reset();
    #2 rst = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(6'b0, 0, i < 2, pc);
      if (m_acc) pc += 4;
      if (id_valid && first_pc_ok == 0) first_pc_ok = (id_pc === 32'h200) ? 1 : 2;
    end
    checks++;
    if (first_pc_ok != 1) begin
      errors++; $display("FAIL rstmid_first: got code %0d required 1 (first id_pc 00000200)", first_pc_ok);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] pc = 32'h0;
    logic [31:0] got[$];
    logic [5:0]  st;
    int          cyc = 0;
    do_reset();
    while (got.size() < 8 && cyc < 200) begin
      st = {3'b000, 1'($urandom_range(0, 1)), 1'(cyc % 2), 1'b0};
      cycle(st, 0, pc < 32'h20, pc);
      if (m_acc) pc += 4;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL alt_cycle%0d: got %h required %h", cyc, dut_vec, model_vec());
      end
      if (!st[1] && id_valid) got.push_back(id_pc);
      cyc++;
    end
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL alt_budget: got %0d instructions required 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got[k] !== 32'(k * 4)) begin
          errors++; $display("FAIL alt_order%0d: got %h required %h", k, got[k], 32'(k * 4));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] pc = 32'h1000;
    logic [5:0]  st;
    bit          fl;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      st = {3'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 3) == 0)};
      fl = ($urandom_range(0, 15) == 0);
      cycle(st, fl, 1'($urandom_range(0, 3) != 0), pc);
      if (fl) pc = 32'h8000 + 32'(i * 16);
      else if (m_acc) pc += 4;
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL rand_cycle%0d: got %h required %h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_bubble();
    test_flush();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch buffer between the PC register / instruction ROM and the decode stage; replaces a bare IF/ID register.
- Captures each accepted fetch PC, pairs it with the ROM word returned one cycle later, and queues {pc, inst} in a small FIFO.
- Presents the queue head to ID under the pipeline stall/flush controls.
- Raises a back-pressure request to the stall controller when the queue cannot absorb further fetches.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ADDR_W, 32, PC width
DATA_W, 32, instruction width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
stall  input  6  pipeline stall vector; bit0 = PC/IF, bit1 = ID, bit2 = EX
flush  input  1  pipeline flush (exception/eret)
ce_i  input  1  chip enable from the PC register
pc_i  input  ADDR_W  current fetch PC, also driving the ROM address
inst_i  input  DATA_W  ROM read data, valid the cycle after its address
id_pc  output  ADDR_W  PC presented to decode
id_inst  output  DATA_W  instruction presented to decode; 0 (nop) on bubble
id_valid  output  1  id_pc/id_inst hold a real instruction
fetch_stall_req  output  1  back-pressure to the stall controller
count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Reset:
- rst=1 asynchronously clears the FIFO pointers, count, pending slot (req_valid, req_pc), id_pc, id_inst and id_valid to 0.
- fetch_stall_req=0 after reset.
Back-pressure and fetch acceptance:
- fetch_stall_req = (count + req_valid >= DEPTH). Decoded from registers only, no input path.
- Fetch accept in cycle t: accept = ce_i & ~stall[0] & ~flush & ~fetch_stall_req.
- On accept: req_valid<=1 and req_pc<=pc_i at end of t. Otherwise req_valid<=0.
Push:
- In cycle t+1 with req_valid=1 and no flush, {req_pc, inst_i} is written at the tail at end of t+1.
- inst_i is ignored whenever req_valid=0.
Pop / ID register update, at each edge, in priority order:
1. flush=1: FIFO emptied (pointers and count = 0), req_valid=0, id_pc=0, id_inst=0, id_valid=0. Any response arriving next cycle is dropped.
2. stall[1]=1 and stall[2]=0: bubble into ID (id_inst=0, id_pc=0, id_valid=0). No pop.
3. stall[1]=1 and stall[2]=1: ID outputs hold. No pop.
4. stall[1]=0 and count>0: pop the head into id_pc/id_inst; id_valid=1.
5. stall[1]=0 and count=0: bubble (zeros, id_valid=0).
Simultaneous events:
- Push and pop in the same cycle: count is unchanged, pointers both advance.
- Pointers wrap modulo DEPTH.
- The acceptance rule guarantees a push never occurs when the FIFO is full. The bench asserts this.
- Pop from empty never occurs.
Latency:
- Without bypass, pc_i accepted in cycle t appears on ID outputs in cycle t+3 (if ID is not stalled).
Order:
- Strict program order. Branch redirection is handled upstream; this block does not squash on branch.

Optional Feature:
Macro FETCH_BYPASS_EN.
- Defined: when count=0, req_valid=1, stall[1]=0 and flush=0, {req_pc, inst_i} goes directly into the ID registers at end of t+1 and is not pushed. Latency becomes 2 cycles.
- When the bypass path is taken, count + req_valid >= DEPTH never holds.
- Undefined: every response passes through the FIFO. Latency is always 3 cycles.

Test Plan:
- Reset, then ce_i=1, pc_i = 0x0, 0x4, 0x8 on consecutive cycles, ROM returns 0x2401000N, no stalls -> id_pc = 0x0, 0x4, 0x8 with id_valid=1, starting 3 cycles after the first accept (2 with FETCH_BYPASS_EN). count never exceeds 1 (0 with bypass).
- Hold stall[1]=stall[2]=1 while fetching continuously from 0x100 (DEPTH=4) -> count reaches 4 and fetch_stall_req=1 once count+req_valid=4. No overflow. On release, ID sees 0x100..0x10C in order, no gaps or duplicates.
- stall[1]=1, stall[2]=0 for one cycle with queued entries -> id_inst=0, id_valid=0 that cycle. The head is not lost and appears the following cycle.
- flush pulse with count=3 and req_valid=1 -> next cycle count=0, id_valid=0, id_inst=0. The ROM word returned the cycle after flush never appears at ID. Fetch from new_pc=0x4000_0180 proceeds normally.
- Assert rst mid-stream with count=2 -> all outputs 0 immediately, without waiting for a clock edge. After release, the first ID instruction is from the first post-reset fetch.
- Alternate stall[1] every cycle while fetching 8 instructions -> pointers wrap (DEPTH=4). ID order is 0x0..0x1C exactly once each, and count equals pushes minus pops at every cycle.
